// File: rtl/bitcoin_result_scan.sv
// -----------------------------------------------------------------------------
// bitcoin_result_scan
//
// Purpose:
//   Runs after bitcoin_hash on the shared single-port memory. It reads back the
//   NUM_NONCES per-nonce H0 words stored at output_addr+nonce and compares each
//   one, as an unsigned value, against a latched difficulty target. It counts
//   the hits, tracks the smallest hash and its nonce (the lowest nonce wins a
//   tie), and then writes one summary word {found, 15'b0, hit_count, best_nonce}
//   to summary_addr.
//
// Ports:
//   clk, reset        clock; asynchronous active-high reset
//   start             begin a scan (only honoured in IDLE)
//   output_addr       address of the result word for nonce 0
//   summary_addr      address that receives the summary word
//   target            a word is a hit when word < target
//   done              one-cycle pulse once the summary write has been issued
//   found, hit_count  hit flag and hit count of the last scan
//   best_nonce/hash   smallest hash of the last scan and its nonce
//   mem_*             memory port (mem_clk = clk, address/data registered,
//                     read data returns one cycle after the address)
//
// Configuration macro:
//   SCAN_EARLY_EXIT_EN  when defined, the scan stops at the first hit and goes
//                       straight to the summary write. When undefined (the
//                       default), every scan covers all NUM_NONCES words.
// -----------------------------------------------------------------------------
module bitcoin_result_scan #(
    parameter int NUM_NONCES = 16,
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] output_addr,
    input  logic [ADDR_W-1:0] summary_addr,
    input  logic [DATA_W-1:0] target,
    output logic              done,
    output logic              found,
    output logic [7:0]        hit_count,
    output logic [7:0]        best_nonce,
    output logic [DATA_W-1:0] best_hash,
    output logic              mem_clk,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] mem_read_data
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        DRAIN = 3'd2,
        WRITE = 3'd3,
        FIN   = 3'd4
    } state_t;

    localparam logic [7:0] LAST_IDX = 8'(NUM_NONCES - 1);

    state_t            state;
    state_t            state_nxt;
    logic [7:0]        idx;
    logic [DATA_W-1:0] target_q;
    logic [ADDR_W-1:0] summary_addr_q;

    logic              vld_p0;
    logic [7:0]        nonce_p0;
    logic              hit_p0;
    logic              better_p0;
    logic              early_stop;

    // Hit counter increment that can never wrap.
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Summary word: found in the MSB, hit_count in [15:8], best_nonce in [7:0].
    function automatic logic [DATA_W-1:0] pack_summary(input logic       f,
                                                       input logic [7:0] hc,
                                                       input logic [7:0] bn);
        logic [DATA_W-1:0] s;
        s           = '0;
        s[7:0]      = bn;
        s[15:8]     = hc;
        s[DATA_W-1] = f;
        return s;
    endfunction

    assign mem_clk = clk;

    // Read-data stage: in READ the word on mem_read_data belongs to the address
    // issued one cycle earlier (nonce idx-1); the first READ cycle carries no
    // valid word. DRAIN carries the final word, whose nonce equals idx.
    assign vld_p0    = ((state == READ) && (idx != 8'd0)) || (state == DRAIN);
    assign nonce_p0  = (state == DRAIN) ? idx : idx - 8'd1;
    assign hit_p0    = mem_read_data < target_q;
    assign better_p0 = mem_read_data < best_hash;

`ifdef SCAN_EARLY_EXIT_EN
    assign early_stop = vld_p0 && hit_p0;
`else
    assign early_stop = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = READ;
            READ: begin
                if (early_stop) begin
                    state_nxt = WRITE;
                end else if (idx == LAST_IDX) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN:   state_nxt = WRITE;
            WRITE:   state_nxt = FIN;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done           <= 1'b0;
            found          <= 1'b0;
            hit_count      <= 8'd0;
            best_nonce     <= 8'd0;
            best_hash      <= '1;
            mem_we         <= 1'b0;
            mem_addr       <= '0;
            mem_write_data <= '0;
            idx            <= 8'd0;
            target_q       <= '0;
            summary_addr_q <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        target_q       <= target;
                        summary_addr_q <= summary_addr;
                        mem_addr       <= output_addr;
                        idx            <= 8'd0;
                        found          <= 1'b0;
                        hit_count      <= 8'd0;
                        best_hash      <= '1;
                        best_nonce     <= 8'd0;
                    end
                end
                READ: begin
                    // Address wraps naturally at 2^ADDR_W.
                    if ((idx != LAST_IDX) && !early_stop) begin
                        mem_addr <= mem_addr + ADDR_W'(1);
                        idx      <= idx + 8'd1;
                    end
                end
                WRITE: begin
                    mem_we         <= 1'b1;
                    mem_addr       <= summary_addr_q;
                    mem_write_data <= pack_summary(found, hit_count, best_nonce);
                end
                FIN: begin
                    mem_we <= 1'b0;
                    done   <= 1'b1;
                end
                default: ;
            endcase

            // Evaluation stage: strict compare keeps the lowest nonce on ties
            // and leaves an all-ones first word from replacing the initial '1.
            if (vld_p0) begin
                if (hit_p0) begin
                    hit_count <= sat_inc(hit_count);
                    found     <= 1'b1;
                end
                if (better_p0) begin
                    best_hash  <= mem_read_data;
                    best_nonce <= nonce_p0;
                end
            end
        end
    end

endmodule

// File: tb/tb_bitcoin_result_scan.sv
// -----------------------------------------------------------------------------
// tb_bitcoin_result_scan
//
// Bench for bitcoin_result_scan: a single-port memory model, directed scans
// with hand-computed expectations, and a scan model that derives the results
// and the done/write timing straight from the memory contents. A compare
// process checks done, mem_we, the summary write and the held results on every
// cycle. Follows SCAN_EARLY_EXIT_EN when the design is built with it.
// -----------------------------------------------------------------------------
module tb_bitcoin_result_scan;

    localparam int N = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [15:0] output_addr = 16'd0;
    logic [15:0] summary_addr = 16'd0;
    logic [31:0] target = 32'd0;
    logic        done;
    logic        found;
    logic [7:0]  hit_count;
    logic [7:0]  best_nonce;
    logic [31:0] best_hash;
    logic        mem_clk;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    bitcoin_result_scan #(.NUM_NONCES(N), .ADDR_W(16), .DATA_W(32)) dut (
        .clk(clk), .reset(reset), .start(start),
        .output_addr(output_addr), .summary_addr(summary_addr), .target(target),
        .done(done), .found(found), .hit_count(hit_count),
        .best_nonce(best_nonce), .best_hash(best_hash),
        .mem_clk(mem_clk), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
    );

    always #5 clk = ~clk;

    // ---------------- memory model ----------------
    logic [31:0] mem [0:65535];
    logic [31:0] rd;
    int          wr_count = 0;

    assign mem_read_data = rd;

    always @(posedge mem_clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_write_data;
            wr_count      <= wr_count + 1;
        end
        rd <= mem[mem_addr];
    end

    // ---------------- check bookkeeping ----------------
    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // ---------------- scan model ----------------
    typedef struct packed {
        logic        f;
        logic [7:0]  hc;
        logic [7:0]  bn;
        logic [31:0] bh;
        logic [7:0]  lat;
    } res_t;

    function automatic res_t scan_model(input logic [15:0] base, input logic [31:0] tg);
        res_t        r;
        logic [31:0] w;
        r.f   = 1'b0;
        r.hc  = 8'd0;
        r.bn  = 8'd0;
        r.bh  = 32'hFFFF_FFFF;
        r.lat = 8'(N + 3);
        for (int i = 0; i < N; i++) begin
            w = mem[base + 16'(i)];
`ifdef SCAN_EARLY_EXIT_EN
            if (w < tg) begin
                r.f = 1'b1; r.hc = 8'd1; r.bn = 8'(i); r.bh = w; r.lat = 8'(i + 4);
                break;
            end
`else
            if (w < tg) begin
                r.f  = 1'b1;
                r.hc = r.hc + 8'd1;
            end
            if (w < r.bh) begin
                r.bh = w;
                r.bn = 8'(i);
            end
`endif
        end
        return r;
    endfunction

    function automatic logic [31:0] sum_word(input res_t r);
        return {r.f, 15'd0, r.hc, r.bn};
    endfunction

    logic        m_busy = 1'b0;
    int          m_cnt = 0;
    logic        m_done = 1'b0;
    logic        m_fresh = 1'b1;
    logic        m_found = 1'b0;
    logic [7:0]  m_hc = 8'd0;
    logic [7:0]  m_bn = 8'd0;
    logic [31:0] m_bh = 32'hFFFF_FFFF;
    logic [15:0] m_sum_addr = 16'd0;
    res_t        p = '0;
    logic        exp_we;

    // Summary write is in flight on the cycle just before done.
    assign exp_we = m_busy && (m_cnt == int'(p.lat) - 1);

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_busy  <= 1'b0;
            m_cnt   <= 0;
            m_done  <= 1'b0;
            m_fresh <= 1'b1;
            m_found <= 1'b0;
            m_hc    <= 8'd0;
            m_bn    <= 8'd0;
            m_bh    <= 32'hFFFF_FFFF;
        end else begin
            m_done <= 1'b0;
            if (!m_busy) begin
                if (start) begin
                    p          <= scan_model(output_addr, target);
                    m_busy     <= 1'b1;
                    m_cnt      <= 0;
                    m_fresh    <= 1'b0;
                    m_sum_addr <= summary_addr;
                end
            end else begin
                m_cnt <= m_cnt + 1;
                if (m_cnt + 1 == int'(p.lat)) begin
                    m_busy  <= 1'b0;
                    m_done  <= 1'b1;
                    m_found <= p.f;
                    m_hc    <= p.hc;
                    m_bn    <= p.bn;
                    m_bh    <= p.bh;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("done", 32'(done), 32'(m_done));
            check("mem_we", 32'(mem_we), 32'(exp_we));
            if (exp_we) begin
                check("summary_addr", 32'(mem_addr), 32'(m_sum_addr));
                check("summary_data", mem_write_data, sum_word(p));
            end
            if (!m_busy) begin
                check("found", 32'(found), 32'(m_found));
                check("hit_count", 32'(hit_count), 32'(m_hc));
                check("best_nonce", 32'(best_nonce), 32'(m_bn));
                check("best_hash", best_hash, m_bh);
            end
            if (m_fresh) begin
                check("reset_mem_addr", 32'(mem_addr), 32'd0);
                check("reset_mem_wdata", mem_write_data, 32'd0);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic load(input logic [15:0] a, input logic [31:0] d);
        mem[a] <= d;
    endtask

    // Called at posedge+1; start is sampled at the next edge (edge 0) and the
    // returned latency is the edge count after which done was seen high.
    task automatic run_scan(input logic [15:0] oa, input logic [15:0] sa,
                            input logic [31:0] tg, input bit hold, output int lat_seen);
        output_addr  = oa;
        summary_addr = sa;
        target       = tg;
        start        = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
        lat_seen = -1;
        for (int e = 1; e <= 300; e++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat_seen = e;
                break;
            end
        end
        start = 1'b0;
        if (lat_seen < 0) check("done_timeout", 32'(done), 32'd1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic load_t1();
        // 16 * 32'h1000_0000 would wrap to 0, so the last word is all ones.
        for (int i = 0; i < 15; i++) load(16'(100 + i), 32'h1000_0000 * (i + 1));
        load(16'd115, 32'hFFFF_FFFF);
    endtask

    int lat;
    int wr_before;

    initial begin
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset  = 1'b0;
        chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Test 1: hits at nonces 0 and 1.
        load_t1();
        wr_before = wr_count;
        run_scan(16'd100, 16'd200, 32'h3000_0000, 1'b0, lat);
`ifdef SCAN_EARLY_EXIT_EN
        check("t1_latency", 32'(lat), 32'd4);
        check("t1_hit_count", 32'(hit_count), 32'd1);
        check("t1_mem200", mem[200], 32'h8000_0100);
`else
        check("t1_latency", 32'(lat), 32'd19);
        check("t1_hit_count", 32'(hit_count), 32'd2);
        check("t1_mem200", mem[200], 32'h8000_0200);
`endif
        check("t1_best_nonce", 32'(best_nonce), 32'd0);
        check("t1_best_hash", best_hash, 32'h1000_0000);
        check("t1_writes", 32'(wr_count - wr_before), 32'd1);

        // Test 2: target 0, no hits possible.
        for (int i = 0; i < 16; i++) load(16'(100 + i), 32'hABCD_0000);
        run_scan(16'd100, 16'd200, 32'd0, 1'b0, lat);
        check("t2_latency", 32'(lat), 32'd19);
        check("t2_found", 32'(found), 32'd0);
        check("t2_hit_count", 32'(hit_count), 32'd0);
        check("t2_best_hash", best_hash, 32'hABCD_0000);
        check("t2_mem200", mem[200], 32'h0000_0000);

        // Test 3: base wraps past FFFF; minimum at 0003 is nonce 11.
        for (int i = 0; i < 16; i++) load(16'hFFF8 + 16'(i), 32'h7000_0000 + 32'(i));
        load(16'h0003, 32'h0000_0005);
        run_scan(16'hFFF8, 16'd200, 32'h0000_0010, 1'b0, lat);
`ifdef SCAN_EARLY_EXIT_EN
        check("t3_latency", 32'(lat), 32'd15);
`else
        check("t3_latency", 32'(lat), 32'd19);
`endif
        check("t3_best_nonce", 32'(best_nonce), 32'd11);
        check("t3_best_hash", best_hash, 32'h0000_0005);
        check("t3_mem200", mem[200], 32'h8000_010B);

        // Test 4: equal minima at nonces 3 and 9, lowest nonce wins.
        for (int i = 0; i < 16; i++) load(16'(300 + i), 32'hFFFF_FFFF);
        load(16'd303, 32'h2000_0000);
        load(16'd309, 32'h2000_0000);
        run_scan(16'd300, 16'd400, 32'h2000_0001, 1'b0, lat);
        check("t4_best_nonce", 32'(best_nonce), 32'd3);
`ifdef SCAN_EARLY_EXIT_EN
        check("t4_mem400", mem[400], 32'h8000_0103);
`else
        check("t4_mem400", mem[400], 32'h8000_0203);
`endif

        // Test 5: all-ones words never replace the initial best.
        for (int i = 0; i < 16; i++) load(16'(500 + i), 32'hFFFF_FFFF);
        run_scan(16'd500, 16'd400, 32'hFFFF_FFFF, 1'b0, lat);
        check("t5_best_hash", best_hash, 32'hFFFF_FFFF);
        check("t5_best_nonce", 32'(best_nonce), 32'd0);
        check("t5_mem400", mem[400], 32'h0000_0000);

        // Test 6: reset at cycle 8 of a scan aborts it without a write.
        for (int i = 0; i < 16; i++) load(16'(100 + i), 32'hABCD_0000);
        wr_before    = wr_count;
        output_addr  = 16'd100;
        summary_addr = 16'd200;
        target       = 32'd0;
        start        = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("t6_found", 32'(found), 32'd0);
        check("t6_best_hash", best_hash, 32'hFFFF_FFFF);
        check("t6_mem_addr", 32'(mem_addr), 32'd0);
        repeat (25) @(posedge clk);
        #1;
        check("t6_no_write", 32'(wr_count - wr_before), 32'd0);
        check("t6_mem200", mem[200], 32'h8000_010B);
        load_t1();
        run_scan(16'd100, 16'd200, 32'h3000_0000, 1'b0, lat);
        check("t6_restart_best", best_hash, 32'h1000_0000);

        // Test 7: start held high through a whole scan gives one write.
        wr_before = wr_count;
        run_scan(16'd100, 16'd200, 32'h3000_0000, 1'b1, lat);
`ifdef SCAN_EARLY_EXIT_EN
        check("t7_latency", 32'(lat), 32'd4);
`else
        check("t7_latency", 32'(lat), 32'd19);
`endif
        repeat (30) @(posedge clk);
        #1;
        check("t7_writes", 32'(wr_count - wr_before), 32'd1);

        // Test 8: only nonce 5 below target.
        for (int i = 0; i < 16; i++) load(16'(600 + i), 32'h9000_0000 + 32'(i));
        load(16'd605, 32'h4000_0000);
        run_scan(16'd600, 16'd700, 32'h5000_0000, 1'b0, lat);
`ifdef SCAN_EARLY_EXIT_EN
        check("t8_latency", 32'(lat), 32'd9);
`else
        check("t8_latency", 32'(lat), 32'd19);
`endif
        check("t8_best_nonce", 32'(best_nonce), 32'd5);
        check("t8_hit_count", 32'(hit_count), 32'd1);
        check("t8_mem700", mem[700], 32'h8000_0105);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
